conv4_psum_accum: RTL and testbench
===================================

Name: conv4_psum_accum

Overview:
- Downstream stage of the conv4 1D-systolic PE rows.
- Collects the 2*conv4_width partial sums from ROWS PE rows on each valid beat and accumulates them over CIN input channels.
- On the last channel it adds bias, round-shifts and saturates, with optional ReLU, producing one conv4_width output activation per output pixel.
- Output uses a valid/ready handshake toward the next layer's buffer and provides ready backpressure to the PE row controller.

Parameters:
- DW, conv4_width: activation/weight width. Psum input is 2*DW.
- ROWS, 3: number of PE rows, i.e. kernel rows, summed per beat.
- CIN, 16: input channels accumulated per output pixel (>=1).
- SHIFT, 6: requantisation right shift (>=1).
- RELU, 1: 1 clamps negative results to 0; 0 passes them through.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- en  in  1  layer enable; low aborts accumulation
- i_psum  in  ROWS x 2*DW  signed partial sums, one per PE row
- i_vld  in  1  i_psum valid
- o_rdy  out  1  block accepts i_psum this cycle
- i_bias  in  2*DW  signed bias for the current output channel, sampled in FIN
- o_act  out  DW  signed requantised activation
- o_vld  out  1  o_act valid
- i_rdy  in  1  downstream accepts o_act
- o_last  out  1  pulses with accepted beat of channel CIN-1 (debug/status)

Behaviour:
- Reset values: all outputs 0; acc=0; ch_cnt=0; state IDLE.
- Accumulator width: ACC_W = 2*DW + $clog2(ROWS*CIN) + 2, signed. All arithmetic is sign-extended to ACC_W.
- FSM states:
  - IDLE: o_rdy=0. Goes to ACC when en=1; acc and ch_cnt are cleared on entry.
  - ACC: o_rdy=en. A beat is accepted when i_vld && o_rdy.
    - On accept: acc <= acc + sum(i_psum[0..ROWS-1]) and ch_cnt++. The row sum is combinational, single cycle.
    - Accept with ch_cnt==CIN-1 -> FIN; o_last=1 that cycle; ch_cnt wraps to 0.
    - en=0 in ACC -> IDLE; partial acc is discarded and no output is produced.
  - FIN (1 cycle): o_rdy=0.
    - t = acc + bias
    - r = (t + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round half up)
    - ReLU applied if RELU=1
    - saturate to [-2^(DW-1), 2^(DW-1)-1]
    - Registers o_act, sets o_vld=1, clears acc -> OUT.
  - OUT: o_rdy=0; o_vld and o_act held stable until i_rdy.
    - On i_rdy: o_vld<=0; go to ACC if en=1, else IDLE.
    - en dropping in OUT does not cancel the pending output.
- Latency: final beat accepted at cycle t gives o_vld=1 at t+2. Maximum throughput is one output per CIN+2 cycles.
- i_rdy is ignored while o_vld=0. i_vld is ignored while o_rdy=0, and upstream must hold the data.
- CIN=1: every accepted beat goes directly to FIN.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); any pending output is lost.
- No overflow inside acc by construction. Saturation is applied only at the output.

Decomposition:
- Package `definition` holds: conv4_width, the state enum type, the ACC_W computation function, and saturation min/max constants.
- One natural sub-module: `requant_sat`, purely combinational. Inputs are acc and bias; output is the rounded, shifted, ReLU'd, saturated DW result. It is reused by other conv stages.
- FSM, counter and accumulator stay in the top module.

Test Plan:
All scenarios use DW=8, ROWS=3, CIN=4, SHIFT=2.
1. Basic sum: RELU=1, all rows 10 for 4 beats, bias=4 -> acc=120, t=124, o_act=31. o_vld rises 2 cycles after the 4th beat; o_last pulses on the 4th beat.
2. Rounding: rows {42,42,42} for 1 beat, then zeros for 3 beats, bias=0 -> t=126, (126+2)>>2 = o_act=32.
3. Saturation: rows 1000 each for 4 beats -> o_act=127. With RELU=0, rows -1000 -> o_act=-128. With RELU=1, rows -1000 -> 0.
4. Backpressure: hold i_rdy=0 for 5 cycles after o_vld -> o_vld/o_act stable and o_rdy=0 throughout. Raise i_rdy -> one transfer, then ACC. Next pixel with rows 1 each and bias 0 -> (12+2)>>2 = o_act=3.
5. Abort: drop en after 2 accepted beats -> IDLE and no o_vld. Re-enable and send 4 beats of rows 10 with bias 4 -> o_act=31, with no contamination from the aborted beats.
6. Reset: assert rstn=0 while in OUT with o_vld=1 -> o_vld=0, o_act=0, o_rdy=0 immediately. After release, state is IDLE and ch_cnt=0.

Source files
------------

// File: rtl/conv4_psum_accum_pkg.sv
// Shared definitions for the conv4 psum accumulator and its requant stage.
//   CONV4_WIDTH      default activation/weight width
//   state_t          accumulator FSM states
//   acc_width()      accumulator width that cannot overflow over ROWS*CIN psums
//   sat_max/sat_min  signed output clamp limits for a given width
package conv4_psum_accum_pkg;

  localparam int CONV4_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_FIN  = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Two headroom bits on top of the log2 growth cover the bias add and
  // the rounding constant without wrapping.
  function automatic int acc_width(input int dw, input int rows, input int cin);
    return 2*dw + $clog2(rows*cin) + 2;
  endfunction

  function automatic longint sat_max(input int dw);
    return (longint'(1) << (dw-1)) - 1;
  endfunction

  function automatic longint sat_min(input int dw);
    return -(longint'(1) << (dw-1));
  endfunction

  localparam longint CONV4_SAT_MAX = sat_max(CONV4_WIDTH);
  localparam longint CONV4_SAT_MIN = sat_min(CONV4_WIDTH);

endpackage

// File: rtl/conv4_psum_accum_requant_sat.sv
// requant_sat: combinational requantisation of an accumulated psum.
//   acc   in  ACC_W    signed accumulator
//   bias  in  2*DW     signed bias
//   act   out DW       (acc+bias + 2^(SHIFT-1)) >>> SHIFT, optional ReLU, saturated
module requant_sat
  import conv4_psum_accum_pkg::*;
#(
  parameter int DW    = CONV4_WIDTH,
  parameter int ACC_W = 2*CONV4_WIDTH + 8,
  parameter int SHIFT = 6,
  parameter int RELU  = 1
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [2*DW-1:0]  bias,
  output logic signed [DW-1:0]    act
);

  // One extra bit so bias and rounding never wrap the intermediate.
  localparam int TW = ACC_W + 1;
  localparam logic signed [TW-1:0] RND    = TW'(longint'(1) << (SHIFT-1));
  localparam logic signed [TW-1:0] SAT_HI = TW'(sat_max(DW));
  localparam logic signed [TW-1:0] SAT_LO = TW'(sat_min(DW));

  logic signed [TW-1:0] t, r;

  always_comb begin
    t = {acc[ACC_W-1], acc} + {{(TW-2*DW){bias[2*DW-1]}}, bias};
    r = (t + RND) >>> SHIFT;
    if (RELU != 0 && r < 0) r = '0;
    if (r > SAT_HI)      r = SAT_HI;
    else if (r < SAT_LO) r = SAT_LO;
    act = r[DW-1:0];
  end

endmodule

// File: rtl/conv4_psum_accum.sv
// conv4_psum_accum: sums ROWS PE-row psums per beat, accumulates CIN beats,
// then requantises (bias, round-shift, ReLU, saturate) into one activation.
//   clk, rstn  clock / async active-low reset
//   en         layer enable; low in ACC discards the partial pixel
//   i_psum     ROWS x 2*DW signed psums, i_vld valid, o_rdy accept
//   i_bias     2*DW signed bias, sampled in FIN
//   o_act      DW signed activation, o_vld valid, i_rdy downstream accept
//   o_last     high on the accepted beat of the final channel
module conv4_psum_accum
  import conv4_psum_accum_pkg::*;
#(
  parameter int DW    = CONV4_WIDTH,
  parameter int ROWS  = 3,
  parameter int CIN   = 16,
  parameter int SHIFT = 6,
  parameter int RELU  = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           en,
  input  logic [ROWS-1:0][2*DW-1:0]      i_psum,
  input  logic                           i_vld,
  output logic                           o_rdy,
  input  logic signed [2*DW-1:0]         i_bias,
  output logic signed [DW-1:0]           o_act,
  output logic                           o_vld,
  input  logic                           i_rdy,
  output logic                           o_last
);

  localparam int ACC_W = acc_width(DW, ROWS, CIN);
  localparam int CNT_W = (CIN > 1) ? $clog2(CIN) : 1;

  state_t state, nxt;
  logic signed [ACC_W-1:0]        acc;
  logic [CNT_W-1:0]               ch_cnt;
  logic [ROWS-1:0][ACC_W-1:0]     psum_ext;
  logic [ACC_W-1:0]               row_sum;
  logic signed [DW-1:0]           rq;
  logic                           accept, ch_last;

  for (genvar g = 0; g < ROWS; g++) begin : g_ext
    assign psum_ext[g] = {{(ACC_W-2*DW){i_psum[g][2*DW-1]}}, i_psum[g]};
  end

  always_comb begin
    row_sum = '0;
    for (int r = 0; r < ROWS; r++) row_sum = row_sum + psum_ext[r];
  end

  assign o_rdy   = (state == S_ACC) && en;
  assign accept  = i_vld && o_rdy;
  assign ch_last = (ch_cnt == CNT_W'(CIN-1));
  assign o_last  = accept && ch_last;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (en) nxt = S_ACC;
      S_ACC:  if (!en) nxt = S_IDLE;
              else if (accept && ch_last) nxt = S_FIN;
      S_FIN:  nxt = S_OUT;
      S_OUT:  if (i_rdy) nxt = en ? S_ACC : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc    <= '0;
      ch_cnt <= '0;
      o_act  <= '0;
      o_vld  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (en) begin
          acc    <= '0;
          ch_cnt <= '0;
        end
        S_ACC: if (!en) begin
          acc    <= '0;
          ch_cnt <= '0;
        end else if (accept) begin
          acc    <= acc + row_sum;
          ch_cnt <= ch_last ? '0 : ch_cnt + CNT_W'(1);
        end
        S_FIN: begin
          o_act <= rq;
          o_vld <= 1'b1;
          acc   <= '0;
        end
        S_OUT: if (i_rdy) o_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  requant_sat #(
    .DW(DW), .ACC_W(ACC_W), .SHIFT(SHIFT), .RELU(RELU)
  ) u_rq (
    .acc  (acc),
    .bias (i_bias),
    .act  (rq)
  );

endmodule

// File: tb/tb_conv4_psum_accum.sv
// Directed bench for conv4_psum_accum: DW=8, ROWS=3, CIN=4, SHIFT=2.
// Two instances share stimulus: dut (RELU=1) and dut_n (RELU=0).
module tb_conv4_psum_accum;

  localparam int DW = 8, ROWS = 3, CIN = 4, SHIFT = 2;

  logic clk = 1'b0;
  logic rstn, en, i_vld, i_rdy;
  logic [ROWS-1:0][2*DW-1:0] psum;
  logic signed [2*DW-1:0] bias;
  logic o_rdy, o_vld, o_last;
  logic signed [DW-1:0] o_act;
  logic o_rdy_n, o_vld_n, o_last_n;
  logic signed [DW-1:0] o_act_n;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  conv4_psum_accum #(.DW(DW), .ROWS(ROWS), .CIN(CIN), .SHIFT(SHIFT), .RELU(1)) dut (
    .clk(clk), .rstn(rstn), .en(en), .i_psum(psum), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_bias(bias), .o_act(o_act), .o_vld(o_vld), .i_rdy(i_rdy), .o_last(o_last));

  conv4_psum_accum #(.DW(DW), .ROWS(ROWS), .CIN(CIN), .SHIFT(SHIFT), .RELU(0)) dut_n (
    .clk(clk), .rstn(rstn), .en(en), .i_psum(psum), .i_vld(i_vld), .o_rdy(o_rdy_n),
    .i_bias(bias), .o_act(o_act_n), .o_vld(o_vld_n), .i_rdy(i_rdy), .o_last(o_last_n));

  task automatic chk(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the edge that takes the beat.
  task automatic beat(input int a, input int b, input int c, input bit last);
    psum[0] = 16'(a);
    psum[1] = 16'(b);
    psum[2] = 16'(c);
    i_vld = 1'b1;
    #2;
    chk("beat_rdy", o_rdy, 1);
    chk("beat_last", o_last, last);
    @(posedge clk); #1;
    i_vld = 1'b0;
  endtask

  task automatic pix_const(input int v, input int b);
    bias = 16'(b);
    for (int i = 0; i < CIN; i++) beat(v, v, v, i == CIN-1);
  endtask

  // Entered in FIN; checks o_vld timing, holds i_rdy low for 'hold' cycles.
  task automatic finish(input int exp, input int exp_n, input int hold);
    chk("fin_vld", o_vld, 0);
    chk("fin_rdy", o_rdy, 0);
    @(posedge clk); #1;
    chk("out_vld", o_vld, 1);
    chk("out_act", o_act, exp);
    chk("out_act_norelu", o_act_n, exp_n);
    for (int i = 0; i < hold; i++) begin
      i_rdy = 1'b0;
      @(posedge clk); #1;
      chk("hold_vld", o_vld, 1);
      chk("hold_act", o_act, exp);
      chk("hold_rdy", o_rdy, 0);
    end
    i_rdy = 1'b1;
    @(posedge clk); #1;
    i_rdy = 1'b0;
    chk("xfer_vld", o_vld, 0);
    chk("post_rdy", o_rdy, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; en = 1'b0; i_vld = 1'b0; i_rdy = 1'b0;
    psum = '0; bias = '0;
    #1;
    chk("rst_vld", o_vld, 0);
    chk("rst_act", o_act, 0);
    chk("rst_rdy", o_rdy, 0);
    chk("rst_last", o_last, 0);
    @(posedge clk); #1;
    rstn = 1'b1; en = 1'b1;
    #1;
    chk("idle_rdy", o_rdy, 0);
    @(posedge clk); #1;

    // 1. basic: 3*10*4 + 4 = 124 -> 31
    pix_const(10, 4);
    finish(31, 31, 0);

    // 2. rounding: 126 + 2 >> 2 = 32
    bias = 16'sd0;
    beat(42, 42, 42, 0);
    beat(0, 0, 0, 0);
    beat(0, 0, 0, 0);
    beat(0, 0, 0, 1);
    finish(32, 32, 0);

    // 3. saturation both directions, ReLU vs pass-through
    pix_const(1000, 0);
    finish(127, 127, 0);
    pix_const(-1000, 0);
    finish(0, -128, 0);

    // 4. backpressure, then a small pixel: (12+2)>>2 = 3
    pix_const(10, 4);
    finish(31, 31, 5);
    pix_const(1, 0);
    finish(3, 3, 0);

    // 5. abort after two beats, then a clean pixel
    bias = 16'sd4;
    beat(50, 50, 50, 0);
    beat(50, 50, 50, 0);
    en = 1'b0;
    #2;
    chk("abort_rdy", o_rdy, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("abort_vld", o_vld, 0);
      @(posedge clk); #1;
    end
    en = 1'b1;
    #1;
    chk("abort_idle_rdy", o_rdy, 0);
    @(posedge clk); #1;
    pix_const(10, 4);
    finish(31, 31, 0);

    // 6. reset while an output is pending
    pix_const(10, 4);
    chk("pre_rst_fin_vld", o_vld, 0);
    @(posedge clk); #1;
    chk("pre_rst_vld", o_vld, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld", o_vld, 0);
    chk("mid_rst_act", o_act, 0);
    chk("mid_rst_act_norelu", o_act_n, 0);
    chk("mid_rst_rdy", o_rdy, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    #1;
    chk("post_rst_idle_rdy", o_rdy, 0);
    @(posedge clk); #1;
    pix_const(10, 4);
    finish(31, 31, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
